// File: rtl/dlx_writeback_if.sv
// Handshake bundle between the DLX MEM stage and write-back, plus the load-data return path.
// valid/ready: a transfer occurs on a rising clk edge where in_valid && in_ready; in_ready never depends on in_valid.
interface dlx_writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic [1:0]  in_addr_lo;
    logic [1:0]  in_size;
    logic        in_signed;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output in_valid, in_kind, in_rd, in_result, in_addr_lo, in_size, in_signed,
        output mem_rvalid, mem_rdata,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_kind, in_rd, in_result, in_addr_lo, in_size, in_signed,
        input  mem_rvalid, mem_rdata,
        output in_ready
    );
endinterface

// File: rtl/dlx_writeback.sv
// DLX write-back stage: accepts retiring instructions, aligns load data, strobes the register-file write port.
// Optional feature macro WB_RETIRE_CNT_EN enables the retired-instruction counter (otherwise tied to 0).
module dlx_writeback #(
    parameter int         XLEN     = 32,
    parameter logic [4:0] LINK_REG = 5'd31
) (
    input  logic             clk,
    input  logic             reset,
    dlx_writeback_if.slave   wb,
    input  logic             flush,
    output logic [XLEN-1:0]  reg_s,
    output logic [4:0]       Rd,
    output logic             reg_s_enable,
    output logic             misalign_err,
    output logic [31:0]      retired_count,
    output logic [1:0]       state_dbg
);
    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_ALU  = 2'b01;
    localparam logic [1:0] KIND_LOAD = 2'b10;
    localparam logic [1:0] KIND_LINK = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        COMMIT    = 2'd2
    } state_e;

    state_e      state;
    logic [4:0]  rd_q;
    logic [1:0]  size_q;
    logic [1:0]  addr_q;
    logic        signed_q;

    logic        accept;
    logic        misaligned;
    logic [4:0]  rd_eff;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;

    assign state_dbg   = state;
    assign wb.in_ready = (state == IDLE) & ~flush & ~reset;
    assign accept      = wb.in_valid & wb.in_ready;
    assign rd_eff      = (wb.in_kind == KIND_LINK) ? LINK_REG : wb.in_rd;

    always_comb begin
        case (wb.in_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = wb.in_addr_lo[0];
            2'b10:   misaligned = |wb.in_addr_lo;
            default: misaligned = 1'b1;
        endcase
    end

    // Big-endian lanes: offset 0 is the most significant byte of the word.
    always_comb begin
        case (addr_q)
            2'd0:    byte_lane = wb.mem_rdata[31:24];
            2'd1:    byte_lane = wb.mem_rdata[23:16];
            2'd2:    byte_lane = wb.mem_rdata[15:8];
            default: byte_lane = wb.mem_rdata[7:0];
        endcase
        half_lane = addr_q[1] ? wb.mem_rdata[15:0] : wb.mem_rdata[31:16];
        case (size_q)
            2'b00:   load_data = {{24{signed_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_data = {{16{signed_q & half_lane[15]}}, half_lane};
            default: load_data = wb.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rd_q         <= 5'd0;
            size_q       <= 2'b00;
            addr_q       <= 2'b00;
            signed_q     <= 1'b0;
            reg_s        <= '0;
            Rd           <= 5'd0;
            reg_s_enable <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            reg_s_enable <= 1'b0;
            misalign_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (wb.in_kind)
                            KIND_ALU, KIND_LINK: begin
                                state        <= COMMIT;
                                reg_s_enable <= (rd_eff != 5'd0);
                                // reg_s/Rd only move on a real write so they always show the last one.
                                if (rd_eff != 5'd0) begin
                                    reg_s <= wb.in_result;
                                    Rd    <= rd_eff;
                                end
                            end
                            KIND_LOAD: begin
                                if (misaligned) begin
                                    misalign_err <= 1'b1;
                                end else begin
                                    state    <= WAIT_LOAD;
                                    rd_q     <= wb.in_rd;
                                    size_q   <= wb.in_size;
                                    addr_q   <= wb.in_addr_lo;
                                    signed_q <= wb.in_signed;
                                end
                            end
                            KIND_NONE: ;
                            default: ;
                        endcase
                    end
                end
                WAIT_LOAD: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (wb.mem_rvalid) begin
                        state        <= COMMIT;
                        reg_s_enable <= (rd_q != 5'd0);
                        if (rd_q != 5'd0) begin
                            reg_s <= load_data;
                            Rd    <= rd_q;
                        end
                    end
                end
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic count_step;

    // Counts entry into COMMIT (any destination) and accepted NONE instructions.
    assign count_step = (accept && (wb.in_kind != KIND_LOAD)) ||
                        ((state == WAIT_LOAD) && !flush && wb.mem_rvalid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_count <= 32'd0;
        end else if (count_step) begin
            retired_count <= retired_count + 32'd1;
        end
    end
`else
    assign retired_count = 32'd0;
`endif
endmodule

// File: tb/tb_dlx_writeback.sv
// Directed bench for dlx_writeback: per-cycle expectations are scheduled by the driver tasks and checked at negedge.
module tb_dlx_writeback;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] reg_s;
    logic [4:0]  Rd;
    logic        reg_s_enable;
    logic        misalign_err;
    logic [31:0] retired_count;
    logic [1:0]  state_dbg;

    dlx_writeback_if wb ();

    dlx_writeback dut (
        .clk          (clk),
        .reset        (reset),
        .wb           (wb),
        .flush        (flush),
        .reg_s        (reg_s),
        .Rd           (Rd),
        .reg_s_enable (reg_s_enable),
        .misalign_err (misalign_err),
        .retired_count(retired_count),
        .state_dbg    (state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // expectations keyed by cycle number
    bit          exp_en[int];
    bit          exp_commit[int];
    bit          exp_none[int];
    bit          exp_busy[int];
    bit          exp_err[int];
    logic [31:0] exp_data[int];
    logic [4:0]  exp_rd[int];

    logic [31:0] last_data = 32'd0;
    logic [4:0]  last_rd = 5'd0;
    logic [31:0] mdl_cnt = 32'd0;
    bit          e_en, e_err, e_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // reference model for load alignment: shift the addressed field down, then extend
    function automatic logic [31:0] align_model(input logic [31:0] d, input logic [1:0] off,
                                                input logic [1:0] size, input bit sgn);
        int          nbits;
        int          sh;
        logic [31:0] mask;
        logic [31:0] v;
        nbits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
        if (nbits == 32) return d;
        sh   = 32 - nbits - 8 * int'(off);
        mask = (32'd1 << nbits) - 32'd1;
        v    = (d >> sh) & mask;
        if (sgn && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    // scoreboard / compare process
    always @(negedge clk) begin
        if (reset) begin
            last_data = 32'd0;
            last_rd   = 5'd0;
            mdl_cnt   = 32'd0;
            chk("rst_enable", 32'(reg_s_enable), 32'd0);
            chk("rst_misalign", 32'(misalign_err), 32'd0);
            chk("rst_ready", 32'(wb.in_ready), 32'd0);
            chk("rst_reg_s", reg_s, 32'd0);
            chk("rst_rd", 32'(Rd), 32'd0);
            chk("rst_count", retired_count, 32'd0);
        end else begin
            e_en   = exp_en.exists(cyc) && exp_en[cyc];
            e_err  = exp_err.exists(cyc) && exp_err[cyc];
            e_busy = exp_busy.exists(cyc) && exp_busy[cyc];
            if (e_en) begin
                last_data = exp_data[cyc];
                last_rd   = exp_rd[cyc];
            end
            if (exp_commit.exists(cyc) && exp_commit[cyc]) mdl_cnt = mdl_cnt + 32'd1;
            if (exp_none.exists(cyc) && exp_none[cyc])     mdl_cnt = mdl_cnt + 32'd1;
            chk("enable", 32'(reg_s_enable), 32'(e_en));
            chk("misalign", 32'(misalign_err), 32'(e_err));
            chk("ready", 32'(wb.in_ready), 32'(!e_busy && !flush));
            chk("reg_s", reg_s, last_data);
            chk("rd", 32'(Rd), 32'(last_rd));
`ifdef WB_RETIRE_CNT_EN
            chk("count", retired_count, mdl_cnt);
`else
            chk("count", retired_count, 32'd0);
`endif
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wb.in_valid   = 1'b0;
        wb.mem_rvalid = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic drive_in(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] result,
                            input logic [1:0] off, input logic [1:0] size, input logic sgn);
        wb.in_valid   = 1'b1;
        wb.in_kind    = kind;
        wb.in_rd      = rd;
        wb.in_result  = result;
        wb.in_addr_lo = off;
        wb.in_size    = size;
        wb.in_signed  = sgn;
    endtask

    // NONE / ALU / LINK; returns with the stage idle
    task automatic send_op(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] result,
                           input bit flush_in_commit);
        int         k;
        logic [4:0] rd_e;
        k = cyc;
        drive_in(kind, rd, result, 2'd0, 2'd2, 1'b0);
        if (kind == 2'b00) begin
            exp_none[k+1] = 1'b1;
            step();
            wb.in_valid = 1'b0;
        end else begin
            rd_e = (kind == 2'b11) ? 5'd31 : rd;
            exp_commit[k+1] = 1'b1;
            exp_busy[k+1]   = 1'b1;
            if (rd_e != 5'd0) begin
                exp_en[k+1]   = 1'b1;
                exp_data[k+1] = result;
                exp_rd[k+1]   = rd_e;
            end
            step();
            wb.in_valid = 1'b0;
            flush = flush_in_commit;
            step();
            flush = 1'b0;
        end
    endtask

    // fmode: 0 normal, 1 flush together with rvalid, 2 flush without rvalid
    task automatic send_load(input logic [4:0] rd, input logic [1:0] off, input logic [1:0] size,
                             input logic sgn, input logic [31:0] rdata, input int wait_n, input int fmode);
        int k;
        int w;
        bit mis;
        k   = cyc;
        mis = (size == 2'd3) || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
        drive_in(2'b10, rd, 32'h5A5A_5A5A, off, size, sgn);
        if (mis) begin
            exp_err[k+1] = 1'b1;
            step();
            wb.in_valid = 1'b0;
            return;
        end
        w = k + 1 + wait_n;
        for (int c = k + 1; c <= w; c++) exp_busy[c] = 1'b1;
        step();
        wb.in_valid  = 1'b0;
        wb.mem_rdata = ~rdata;
        repeat (wait_n) step();
        wb.mem_rvalid = (fmode != 2);
        wb.mem_rdata  = rdata;
        flush         = (fmode != 0);
        if (fmode == 0) begin
            exp_busy[w+1]   = 1'b1;
            exp_commit[w+1] = 1'b1;
            if (rd != 5'd0) begin
                exp_en[w+1]   = 1'b1;
                exp_data[w+1] = align_model(rdata, off, size, sgn);
                exp_rd[w+1]   = rd;
            end
        end
        step();
        wb.mem_rvalid = 1'b0;
        flush         = 1'b0;
        if (fmode == 0) step();
    endtask

    // main sequence
    logic [31:0] cnt0;

    initial begin
        idle_in();
        drive_in(2'b00, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0);
        wb.in_valid  = 1'b0;
        wb.mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        send_op(2'b01, 5'd5, 32'hDEAD_BEEF, 1'b0);
        chk("alu_lit_data", reg_s, 32'hDEAD_BEEF);
        chk("alu_lit_rd", 32'(Rd), 32'd5);

        send_op(2'b01, 5'd7, 32'h0000_1234, 1'b1);
        chk("flush_commit_lit", reg_s, 32'h0000_1234);

        send_op(2'b11, 5'd3, 32'h0000_0100, 1'b0);
        chk("link_lit_data", reg_s, 32'h0000_0100);
        chk("link_lit_rd", 32'(Rd), 32'd31);

        send_op(2'b01, 5'd0, 32'h0000_FFFF, 1'b0);
        chk("rd0_lit_hold", reg_s, 32'h0000_0100);

        send_op(2'b00, 5'd4, 32'h1111_1111, 1'b0);

        send_load(5'd9, 2'd1, 2'd0, 1'b1, 32'h1280_3456, 3, 0);
        chk("lb_lit_data", reg_s, 32'hFFFF_FF80);
        chk("lb_lit_rd", 32'(Rd), 32'd9);

        send_load(5'd10, 2'd2, 2'd1, 1'b0, 32'h0000_8001, 0, 0);
        chk("lhu_lit_data", reg_s, 32'h0000_8001);

        send_load(5'd11, 2'd0, 2'd1, 1'b1, 32'h8001_0000, 1, 0);
        send_load(5'd12, 2'd3, 2'd0, 1'b0, 32'h0000_00F0, 2, 0);
        send_load(5'd13, 2'd0, 2'd2, 1'b1, 32'hCAFE_F00D, 1, 0);
        chk("lw_lit_data", reg_s, 32'hCAFE_F00D);

        send_load(5'd14, 2'd2, 2'd2, 1'b0, 32'h1234_5678, 0, 0);
        send_load(5'd14, 2'd1, 2'd1, 1'b0, 32'h1234_5678, 0, 0);
        send_load(5'd14, 2'd0, 2'd3, 1'b0, 32'h1234_5678, 0, 0);

        send_load(5'd15, 2'd0, 2'd1, 1'b0, 32'h7777_7777, 2, 1);
        send_load(5'd16, 2'd0, 2'd2, 1'b0, 32'h6666_6666, 1, 2);
        chk("flush_lit_hold", reg_s, 32'hCAFE_F00D);

        // flush while idle holds off a presented instruction
        drive_in(2'b01, 5'd17, 32'h0000_0077, 2'd0, 2'd2, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        send_op(2'b01, 5'd17, 32'h0000_0077, 1'b0);

        // stray read data outside WAIT_LOAD
        wb.mem_rvalid = 1'b1;
        wb.mem_rdata  = 32'hBAD0_BAD0;
        step();
        step();
        idle_in();

        send_load(5'd0, 2'd0, 2'd2, 1'b0, 32'h4444_4444, 0, 0);
        send_load(5'd18, 2'd2, 2'd0, 1'b1, 32'h0000_7F00, 0, 0);

        // reset in the middle of a load wait
        drive_in(2'b10, 5'd20, 32'd0, 2'd0, 2'd2, 1'b0);
        exp_busy[cyc+1] = 1'b1;
        step();
        wb.in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        wb.mem_rvalid = 1'b1;
        wb.mem_rdata  = 32'h9999_9999;
        step();
        idle_in();
        chk("reset_lit_data", reg_s, 32'd0);
        chk("reset_lit_rd", 32'(Rd), 32'd0);

        // counter: 3 ALU + 1 NONE + 1 misaligned load
        cnt0 = retired_count;
        send_op(2'b01, 5'd1, 32'h0000_0001, 1'b0);
        send_op(2'b01, 5'd2, 32'h0000_0002, 1'b0);
        send_op(2'b01, 5'd0, 32'h0000_0003, 1'b0);
        send_op(2'b00, 5'd0, 32'h0000_0000, 1'b0);
        send_load(5'd6, 2'd1, 2'd2, 1'b0, 32'h0, 0, 0);
        step();
`ifdef WB_RETIRE_CNT_EN
        chk("count_lit", retired_count - cnt0, 32'd4);
`else
        chk("count_lit", retired_count, 32'd0);
`endif

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
